// File: rtl/increment_sched.sv
// increment_sched: round-robin front end for a shared, 2-stage incrementer.
//
// N requesters offer W-bit operands on valid/ready handshakes. One operand
// per cycle is granted, and y = A+1 (mod 2^W) comes back on a single
// backpressured response port, tagged with the requester index.
//
// Datapath:
//   stage 1: locate the lowest 0 bit of A (one-hot s1_m, zero for all ones)
//   stage 2: y = A ^ inclusive_mask(s1_m), co = (s1_m == 0)
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   req_vld[N]        per-requester operand valid
//   req_a[N*W]        operand for requester i at [i*W +: W]
//   req_rdy[N]        per-requester accept, at most one bit set
//   rsp_vld/rsp_rdy   response handshake
//   rsp_id            requester index of the response
//   rsp_y, rsp_co     incremented result and carry-out
//   fail              sticky self-check error
//
// Optional build macro INCREMENT_SCHED_CHECK_EN: stage 2 also runs a plain
// W+1-bit reference adder and sets fail on any disagreement. Without the
// macro, fail is tied low and no reference adder exists.

module increment_sched #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_vld,
  input  logic [N*W-1:0]       req_a,
  output logic [N-1:0]         req_rdy,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [W-1:0]         rsp_y,
  output logic                 rsp_co,
  output logic                 fail
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          s1_vld;
  logic [IW-1:0] s1_id;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_m;

  logic          s2_load, s1_free, accept;
  logic          gnt_any;
  logic [IW-1:0] gnt_id, gnt_off;
  logic [IW:0]   gnt_sum;
  logic [2*N-1:0] rot;
  logic [W-1:0]  acc_a, acc_m;
  logic [W-1:0]  mask, y_next;
  logic          co_next;

  assign s2_load = !rsp_vld || rsp_rdy;
  assign s1_free = !s1_vld || s2_load;

  // Rotate the valid vector so that bit 0 is the requester at the pointer;
  // the lowest set bit of the rotated window is the offset from the pointer.
  always_comb begin
    rot     = {req_vld, req_vld} >> ptr;
    gnt_any = 1'b0;
    gnt_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_any = 1'b1;
        gnt_off = IW'(k);
      end
    end
    gnt_sum = {1'b0, ptr} + {1'b0, gnt_off};
    if (gnt_sum >= (IW+1)'(N)) gnt_sum = gnt_sum - (IW+1)'(N);
    gnt_id = gnt_sum[IW-1:0];
  end

  assign accept  = s1_free && gnt_any;
  assign req_rdy = accept ? (N'(1) << gnt_id) : '0;

  // Operand of the granted requester and its lowest-zero one-hot.
  always_comb begin
    acc_a = req_a[gnt_id*W +: W];
    acc_m = '0;
    for (int j = W - 1; j >= 0; j--) begin
      if (!acc_a[j]) begin
        acc_m    = '0;
        acc_m[j] = 1'b1;
      end
    end
  end

  // Bits at and below the lowest zero flip. All ones has no zero bit, so
  // every bit flips and the result wraps to 0.
  always_comb begin
    logic run;
    run  = 1'b0;
    mask = '0;
    for (int j = W - 1; j >= 0; j--) begin
      run     = run | s1_m[j];
      mask[j] = run;
    end
    if (s1_m == '0) mask = '1;
    y_next  = s1_a ^ mask;
    co_next = (s1_m == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_id  <= '0;
      s1_a   <= '0;
      s1_m   <= '0;
    end else if (s1_free) begin
      s1_vld <= accept;
      if (accept) begin
        s1_id <= gnt_id;
        s1_a  <= acc_a;
        s1_m  <= acc_m;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_y   <= '0;
      rsp_co  <= 1'b0;
    end else if (s2_load) begin
      rsp_vld <= s1_vld;
      // Data only moves with a real operand; bubbles leave it untouched.
      if (s1_vld) begin
        rsp_id <= s1_id;
        rsp_y  <= y_next;
        rsp_co <= co_next;
      end
    end
  end

`ifdef INCREMENT_SCHED_CHECK_EN
  logic [W:0] ref_sum;
  assign ref_sum = {1'b0, s1_a} + (W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail <= 1'b0;
    end else if (s2_load && s1_vld) begin
      fail <= fail | (ref_sum != {co_next, y_next});
    end
  end
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_increment_sched.sv
module tb_increment_sched;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_a;
  logic [N-1:0]   req_rdy;
  logic           rsp_vld;
  logic           rsp_rdy;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_y;
  logic           rsp_co;
  logic           fail;

  int n_cmp = 0;
  int n_bad = 0;

  increment_sched #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_a(req_a), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_co(rsp_co), .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    req_vld = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_vld = '0; req_a = '0; rsp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rsp_vld, rsp_id, rsp_co, rsp_y, fail} !== 37'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: vld=%b id=%0d co=%b y=%h fail=%b, required all zero",
               rsp_vld, rsp_id, rsp_co, rsp_y, fail);
    end
    rst = 1'b0;
    @(negedge clk);
    req_vld = 4'b0100;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0100) begin
      n_bad++;
      $display("FAIL reset_first_grant: req_rdy=%b, required 0100", req_rdy);
    end
    req_vld = '0;
    do_reset();
  endtask

  task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] ey, input logic eco);
    @(negedge clk);
    req_vld = 4'b0001;
    req_a[0 +: W] = a;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_grant a=%h: req_rdy=%b, required 0001", a, req_rdy);
    end
    @(negedge clk);
    req_vld = '0;
    #1;
    n_cmp++;
    if (rsp_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early a=%h: rsp_vld=%b, required 0", a, rsp_vld);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_vld, rsp_id, rsp_co, rsp_y} !== {1'b1, 2'd0, eco, ey}) begin
      n_bad++;
      $display("FAIL single_rsp a=%h: vld=%b id=%0d co=%b y=%h, required vld=1 id=0 co=%b y=%h",
               a, rsp_vld, rsp_id, rsp_co, rsp_y, eco, ey);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drain a=%h: rsp_vld=%b, required 0", a, rsp_vld);
    end
  endtask

  task automatic test_single();
    single_op(32'h0000_0000, 32'h0000_0001, 1'b0);
    single_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    single_op(32'h0000_00FF, 32'h0000_0100, 1'b0);
    single_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] la [4];
    logic [W-1:0] ly [4];
    logic [3:0]   lco;
    logic [3:0]   eg;
    logic [1:0]   eid;
    la = '{32'h0000_000F, 32'h1234_5678, 32'h8000_FFFF, 32'hFFFF_FFFF};
    ly = '{32'h0000_0010, 32'h1234_5679, 32'h8001_0000, 32'h0000_0000};
    lco = 4'b1000;
    do_reset();
    for (int i = 0; i < N; i++) req_a[i*W +: W] = la[i];
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      req_vld = (n < 10) ? 4'b1111 : 4'b0000;
      #1;
      if (n < 10) begin
        eg = 4'b0001 << (n % 4);
        n_cmp++;
        if (req_rdy !== eg) begin
          n_bad++;
          $display("FAIL b2b_grant n=%0d: req_rdy=%b, required %b", n, req_rdy, eg);
        end
      end
      if (n >= 2) begin
        eid = 2'((n - 2) % 4);
        n_cmp++;
        if ({rsp_vld, rsp_id, rsp_co, rsp_y} !== {1'b1, eid, lco[eid], ly[eid]}) begin
          n_bad++;
          $display("FAIL b2b_rsp n=%0d: vld=%b id=%0d co=%b y=%h, required vld=1 id=%0d co=%b y=%h",
                   n, rsp_vld, rsp_id, rsp_co, rsp_y, eid, lco[eid], ly[eid]);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_tail: rsp_vld=%b, required 0", rsp_vld);
    end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] vin [4];
    logic [3:0] vex [4];
    vin = '{4'b0010, 4'b1010, 4'b0010, 4'b0110};
    vex = '{4'b0010, 4'b1000, 4'b0010, 4'b0100};
    do_reset();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      req_vld = vin[s];
      #1;
      n_cmp++;
      if (req_rdy !== vex[s]) begin
        n_bad++;
        $display("FAIL rr_step%0d: req_vld=%b req_rdy=%b, required %b", s, vin[s], req_rdy, vex[s]);
      end
    end
    @(negedge clk);
    req_vld = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall();
    logic [W-1:0] x, y, z;
    x = 32'h0000_0AFF; y = 32'hDEAD_BEEF; z = 32'h0FFF_FFFF;
    do_reset();
    rsp_rdy = 1'b0;
    @(negedge clk);
    req_vld = 4'b0001; req_a[0 +: W] = x;
    @(negedge clk);
    req_vld = 4'b0010; req_a[W +: W] = y;
    @(negedge clk);
    req_vld = 4'b0100; req_a[2*W +: W] = z;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({req_rdy, rsp_vld, rsp_id, rsp_y} !== {4'b0000, 1'b1, 2'd0, 32'h0000_0B00}) begin
        n_bad++;
        $display("FAIL stall_hold s=%0d: req_rdy=%b vld=%b id=%0d y=%h, required 0000 1 0 00000b00",
                 s, req_rdy, rsp_vld, rsp_id, rsp_y);
      end
    end
    @(negedge clk);
    rsp_rdy = 1'b1;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0100) begin
      n_bad++;
      $display("FAIL stall_release_grant: req_rdy=%b, required 0100", req_rdy);
    end
    @(negedge clk);
    req_vld = '0;
    #1;
    n_cmp++;
    if ({rsp_vld, rsp_id, rsp_y} !== {1'b1, 2'd1, 32'hDEAD_BEF0}) begin
      n_bad++;
      $display("FAIL stall_drain1: vld=%b id=%0d y=%h, required 1 1 deadbef0", rsp_vld, rsp_id, rsp_y);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_vld, rsp_id, rsp_y} !== {1'b1, 2'd2, 32'h1000_0000}) begin
      n_bad++;
      $display("FAIL stall_drain2: vld=%b id=%0d y=%h, required 1 2 10000000", rsp_vld, rsp_id, rsp_y);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_nodup: rsp_vld=%b, required 0", rsp_vld);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rsp_rdy = 1'b0;
    @(negedge clk);
    req_vld = 4'b0001; req_a[0 +: W] = 32'h0000_0005;
    @(negedge clk);
    req_vld = 4'b0010; req_a[W +: W] = 32'h0000_0006;
    @(negedge clk);
    req_vld = '0;
    #1;
    n_cmp++;
    if (rsp_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_full: rsp_vld=%b, required 1", rsp_vld);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_vld, rsp_y} !== 33'h0) begin
      n_bad++;
      $display("FAIL midrst_immediate: vld=%b y=%h, required 0 0", rsp_vld, rsp_y);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_rdy = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_dropped s=%0d: rsp_vld=%b, required 0", s, rsp_vld);
      end
    end
    req_vld = 4'b1111;
    #1;
    n_cmp++;
    if (req_rdy !== 4'b0001) begin
      n_bad++;
      $display("FAIL midrst_ptr: req_rdy=%b, required 0001", req_rdy);
    end
    @(negedge clk);
    req_vld = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [W-1:0] v [40];
    logic [W-1:0] ey;
    for (int i = 0; i < 40; i++) v[i] = $urandom;
    v[0] = 32'hFFFF_FFFF; v[1] = 32'h0000_0000; v[2] = 32'h7FFF_FFFF;
    v[3] = 32'hFFFF_FFFE; v[4] = 32'h0000_FFFF;
    do_reset();
    for (int n = 0; n < 42; n++) begin
      @(negedge clk);
      if (n < 40) begin
        req_vld = 4'b0001;
        req_a[0 +: W] = v[n];
      end else begin
        req_vld = '0;
      end
      #1;
      if (n >= 2) begin
        ey = v[n-2] + 32'd1;
        n_cmp++;
        if ({rsp_vld, rsp_co, rsp_y} !== {1'b1, (v[n-2] == 32'hFFFF_FFFF), ey}) begin
          n_bad++;
          $display("FAIL sweep a=%h: vld=%b co=%b y=%h, required 1 %b %h",
                   v[n-2], rsp_vld, rsp_co, rsp_y, (v[n-2] == 32'hFFFF_FFFF), ey);
        end
      end
    end
    n_cmp++;
    if (fail !== 1'b0) begin
      n_bad++;
      $display("FAIL selfcheck_flag: fail=%b, required 0", fail);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_wrap();
    test_stall();
    test_reset_midflight();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
